// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, text-cell geometry and shared types
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;

  localparam int unsigned H_TOTAL_D      = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int unsigned V_TOTAL_D      = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int unsigned H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
  localparam int unsigned H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int unsigned V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
  localparam int unsigned V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  // 8x16 glyphs on an 80x30 text grid
  localparam int unsigned GLYPH_W   = 8;
  localparam int unsigned GLYPH_H   = 16;
  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned XPIX_W  = $clog2(GLYPH_W);
  localparam int unsigned YPIX_W  = $clog2(GLYPH_H);
  localparam int unsigned COL_W   = $clog2(TEXT_COLS);
  localparam int unsigned ROW_W   = $clog2(TEXT_ROWS);
  localparam int unsigned FRAME_W = 6;

  typedef struct packed {
    logic de;
    logic vsync;
    logic hsync;
  } sync_bus_t;

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth register delay line with per-bit reset value
// DEPTH = 0 degenerates to a wire.
module sync_delay #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, delayed sync/de, text-cell coordinates, blink phases
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [CNT_W-1:0]  hc,
  output logic [CNT_W-1:0]  vc,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [XPIX_W-1:0] xpix,
  output logic [YPIX_W-1:0] ypix,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              sof,
  output logic              blink_cur,
  output logic              blink_attr
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam sync_bus_t SYNC_RST = '{de: 1'b0, vsync: ~SYNC_POL, hsync: ~SYNC_POL};

  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0]   vc_q, vc_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               h_wrap, v_wrap, sof_raw;
  sync_bus_t          sync_raw, sync_dly;

  always_comb begin
    h_wrap  = (32'(hc_q) == H_TOTAL - 1);
    v_wrap  = (32'(vc_q) == V_TOTAL - 1);
    sof_raw = (hc_q == '0) && (vc_q == '0);
    hc_d    = h_wrap ? '0 : hc_q + CNT_W'(1);
    vc_d    = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + CNT_W'(1);
    end
    frame_d = sof_raw ? frame_q + FRAME_W'(1) : frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    sync_raw.hsync = in_window(hc_q, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_raw.vsync = in_window(vc_q, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    sync_raw.de    = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
  end

  // Delay matches the glyph-fetch pipeline so sync/de line up with pixel data
  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign hc    = hc_q;
  assign vc    = vc_q;
  assign col   = hc_q[CNT_W-1:XPIX_W];
  assign row   = vc_q[ROW_W+YPIX_W-1:YPIX_W];
  assign xpix  = hc_q[XPIX_W-1:0];
  assign ypix  = vc_q[YPIX_W-1:0];
  assign hsync = sync_dly.hsync;
  assign vsync = sync_dly.vsync;
  assign de    = sync_dly.de;

  // Counters sit at 0,0 during reset; gating keeps sof low there yet high in the first cycle after release
  assign sof        = sof_raw & rst_n;
  assign blink_cur  = frame_q[4];
  assign blink_attr = frame_q[5];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: default 640x480 instance plus a small fast-frame instance
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic [6:0] col;
    logic [4:0] row;
    logic [2:0] xpix;
    logic [3:0] ypix;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       sof;
    logic       bc;
    logic       ba;
  } obs_t;

  logic clk;
  logic rst_n0, rst_n1;
  logic [9:0] hc0, vc0, hc1, vc1;
  logic [6:0] col0, col1;
  logic [4:0] row0, row1;
  logic [2:0] xpix0, xpix1;
  logic [3:0] ypix0, ypix1;
  logic hs0, vs0, de0, sof0, bc0, ba0;
  logic hs1, vs1, de1, sof1, bc1, ba1;
  obs_t act0, act1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  obs_t q0[$];
  obs_t q1[$];

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst_n0), .hc(hc0), .vc(vc0), .col(col0), .row(row0),
    .xpix(xpix0), .ypix(ypix0), .hsync(hs0), .vsync(vs0), .de(de0), .sof(sof0),
    .blink_cur(bc0), .blink_attr(ba0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .PIPE_DLY(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .hc(hc1), .vc(vc1), .col(col1), .row(row1),
    .xpix(xpix1), .ypix(ypix1), .hsync(hs1), .vsync(vs1), .de(de1), .sof(sof1),
    .blink_cur(bc1), .blink_attr(ba1)
  );

  assign act0 = {hc0, vc0, col0, row0, xpix0, ypix0, hs0, vs0, de0, sof0, bc0, ba0};
  assign act1 = {hc1, vc1, col1, row1, xpix1, ypix1, hs1, vs1, de1, sof1, bc1, ba1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs n clock edges after reset release, from raster arithmetic
  function automatic obs_t model(input int id, input int n, input bit in_rst);
    int ha, hf, hs, hb, va, vf, vs, vb, dly, ht, vt, ft, h, v, m, mh, mv, frames;
    bit pol;
    obs_t e;
    if (id == 0) begin
      ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0; dly = 2;
    end else begin
      ha = 16; hf = 2; hs = 4; hb = 3; va = 8; vf = 1; vs = 2; vb = 2; pol = 1'b1; dly = 3;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ft = ht * vt;
    e = '0;
    e.hsync = ~pol;
    e.vsync = ~pol;
    if (!in_rst) begin
      h = n % ht;
      v = (n / ht) % vt;
      e.hc   = 10'(h);
      e.vc   = 10'(v);
      e.col  = 7'(h / 8);
      e.row  = 5'((v / 16) % 32);
      e.xpix = 3'(h % 8);
      e.ypix = 4'(v % 16);
      e.sof  = (h == 0) && (v == 0);
      frames = (n == 0) ? 0 : (((n - 1) / ft) + 1) % 64;
      e.bc   = ((frames / 16) % 2) == 1;
      e.ba   = ((frames / 32) % 2) == 1;
      if (n >= dly) begin
        m  = n - dly;
        mh = m % ht;
        mv = (m / ht) % vt;
        e.hsync = (mh >= ha + hf && mh < ha + hf + hs) ? pol : ~pol;
        e.vsync = (mv >= va + vf && mv < va + vf + vs) ? pol : ~pol;
        e.de    = (mh < ha) && (mv < va);
      end
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_obs(input string p, input obs_t a, input obs_t e);
    cmp({p, ".hc"},   int'(a.hc),   int'(e.hc));
    cmp({p, ".vc"},   int'(a.vc),   int'(e.vc));
    cmp({p, ".col"},  int'(a.col),  int'(e.col));
    cmp({p, ".row"},  int'(a.row),  int'(e.row));
    cmp({p, ".xpix"}, int'(a.xpix), int'(e.xpix));
    cmp({p, ".ypix"}, int'(a.ypix), int'(e.ypix));
    cmp({p, ".hsync"}, int'(a.hsync), int'(e.hsync));
    cmp({p, ".vsync"}, int'(a.vsync), int'(e.vsync));
    cmp({p, ".de"},   int'(a.de),   int'(e.de));
    cmp({p, ".sof"},  int'(a.sof),  int'(e.sof));
    cmp({p, ".blink_cur"},  int'(a.bc), int'(e.bc));
    cmp({p, ".blink_attr"}, int'(a.ba), int'(e.ba));
  endtask

  task automatic set_rst(input int id, input logic v);
    if (id == 0) rst_n0 = v;
    else rst_n1 = v;
  endtask

  task automatic push(input int id, input obs_t e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reset is changed 2 time units after the edge, so it never coincides with a clock edge
  task automatic drive(input int id, input int ncyc, input int rst_at);
    int n;
    int hold;
    bit running;
    bit done_mid;
    n = 0;
    hold = 3;
    running = 1'b0;
    done_mid = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #2;
      if (running) n++;
      if (running && !done_mid && n == rst_at) begin
        set_rst(id, 1'b0);
        running = 1'b0;
        done_mid = 1'b1;
        hold = $urandom_range(1, 4);
      end else if (!running) begin
        if (hold == 0) begin
          set_rst(id, 1'b1);
          running = 1'b1;
          n = 0;
        end else begin
          hold--;
        end
      end
      push(id, model(id, n, !running));
    end
  endtask

  int hlow0 = 0;
  logic prev_de0 = 1'b0;
  int vhigh1 = 0;
  int last_sof1 = -1;
  int last_bc1 = -1;
  int last_ba1 = -1;
  logic prev_bc1 = 1'b0;
  logic prev_ba1 = 1'b0;

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp_obs("d0", act0, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp_obs("d1", act1, e);
      end
      if (!rst_n0) begin
        hlow0 = 0;
      end else begin
        if (!hs0) hlow0++;
        else if (hlow0 > 0) begin
          cmp("d0.hsync_width", hlow0, 96);
          hlow0 = 0;
        end
        if (prev_de0 && !de0) cmp("d0.de_fall_hc", int'(hc0), 642);
      end
      prev_de0 = de0;
      if (!rst_n1) begin
        vhigh1 = 0;
        last_sof1 = -1;
        last_bc1 = -1;
        last_ba1 = -1;
      end else begin
        if (vs1) vhigh1++;
        else if (vhigh1 > 0) begin
          cmp("d1.vsync_width", vhigh1, 50);
          vhigh1 = 0;
        end
        if (sof1) begin
          if (last_sof1 >= 0) cmp("d1.sof_period", cyc - last_sof1, 325);
          last_sof1 = cyc;
        end
        if (bc1 != prev_bc1) begin
          if (last_bc1 >= 0) cmp("d1.blink_cur_period", cyc - last_bc1, 16 * 325);
          last_bc1 = cyc;
        end
        if (ba1 != prev_ba1) begin
          if (last_ba1 >= 0) cmp("d1.blink_attr_period", cyc - last_ba1, 32 * 325);
          last_ba1 = cyc;
        end
      end
      prev_bc1 = bc1;
      prev_ba1 = ba1;
    end
  end

  initial begin
    int rst_at0;
    int rst_at1;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    rst_at0 = $urandom_range(1, 4) * 800 + 300;
    rst_at1 = 64 * 325 + $urandom_range(20, 300);
    fork
      drive(0, 22000, rst_at0);
      drive(1, 22000, rst_at1);
    join
    @(negedge clk);
    #1;
    cmp("q0_drained", q0.size(), 0);
    cmp("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
